// File: rtl/mysystem_clkgen.sv
// Programmable refclk divider bank: per-channel ratio D and phase P, registered outputs, lock FSM gates all outputs.
// Output latency one refclk edge; cfg requests stall (cfg_ready low) while LOCKING and are taken on the first LOCKED edge.
module mysystem_clkgen #(
    parameter int NUM_CLOCKS  = 2,
    parameter int DIV_WIDTH   = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CHAN_W     = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CHAN_W-1:0]     cfg_chan,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic [DIV_WIDTH-1:0]  cfg_phase,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic                  locked
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0]    LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [CHAN_W:0]   NUM_CH    = (CHAN_W + 1)'(NUM_CLOCKS);

    typedef enum logic {
        LOCKING = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LCW-1:0]        lock_cnt_q, lock_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q   [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]  div_d   [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]  phase_q [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]  phase_d [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]  cnt_q   [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]  cnt_d   [NUM_CLOCKS];
    logic [DIV_WIDTH:0]    half_w  [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] started_q, started_d;
    logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
    logic [NUM_CLOCKS-1:0] outclk_en_q, outclk_en_d;

    logic                  xfer;
    logic                  chan_ok;
    logic [DIV_WIDTH-1:0]  div_clamp;
    logic [DIV_WIDTH-1:0]  phase_clamp;

    assign locked      = (state_q == LOCKED);
    assign cfg_ready   = locked;
    assign outclk      = outclk_q;
    assign outclk_en   = outclk_en_q;
    assign xfer        = cfg_valid && cfg_ready;
    assign chan_ok     = ({1'b0, cfg_chan} < NUM_CH);
    assign div_clamp   = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
    assign phase_clamp = (cfg_phase >= div_clamp) ? (div_clamp - 1'b1) : cfg_phase;

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        div_d       = div_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        started_d   = started_q;
        outclk_d    = '0;
        outclk_en_d = '0;

        case (state_q)
            LOCKING: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            LOCKED: begin
                if (xfer && chan_ok) begin
                    state_d    = LOCKING;
                    lock_cnt_d = '0;
                    for (int i = 0; i < NUM_CLOCKS; i++) begin
                        if (cfg_chan == CHAN_W'(i)) begin
                            div_d[i]   = div_clamp;
                            phase_d[i] = phase_clamp;
                        end
                    end
                end
            end
            default: state_d = LOCKING;
        endcase

        // Outputs are registered, so each channel is advanced to the position it holds in the coming cycle.
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            half_w[i] = ({1'b0, div_q[i]} + 1'b1) >> 1;
            if (state_d != LOCKED) begin
                cnt_d[i]     = '0;
                started_d[i] = 1'b0;
            end else if (state_q != LOCKED) begin
                cnt_d[i]     = '0;
                started_d[i] = (phase_q[i] == '0);
                outclk_d[i]    = started_d[i];
                outclk_en_d[i] = started_d[i];
            end else if (!started_q[i]) begin
                if (cnt_q[i] + 1'b1 == phase_q[i]) begin
                    cnt_d[i]       = '0;
                    started_d[i]   = 1'b1;
                    outclk_d[i]    = 1'b1;
                    outclk_en_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i]       = (cnt_q[i] == div_q[i] - 1'b1) ? '0 : cnt_q[i] + 1'b1;
                outclk_d[i]    = ({1'b0, cnt_d[i]} < half_w[i]);
                outclk_en_d[i] = (cnt_d[i] == '0);
            end
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOCKING;
            lock_cnt_q  <= '0;
            started_q   <= '0;
            outclk_q    <= '0;
            outclk_en_q <= '0;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                div_q[i]   <= DIV_WIDTH'(DEFAULT_DIV);
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            started_q   <= started_d;
            outclk_q    <= outclk_d;
            outclk_en_q <= outclk_en_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
